// File: rtl/plru_repl_ctrl.sv
// Tree-PLRU replacement controller for a 4-way set-associative cache: one request in flight,
// hit way or victim returned two cycles after accept. Optional macro: PLRU_INVALID_FIRST_EN.
module plru_repl_ctrl #(
  parameter int SETS  = 16,
  parameter int SET_W = $clog2(SETS)
) (
  input  logic             clk0,
  input  logic             rst0,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [SET_W-1:0] req_set,
  input  logic             req_hit,
  input  logic [1:0]       req_way,
  output logic             resp_valid,
  output logic [1:0]       resp_way,
  input  logic             flush_req,
  output logic             flush_busy,
  input  logic [3:0]       way_valid
);

  typedef enum logic [1:0] {IDLE, LOOKUP, UPDATE, FLUSH} state_t;

  localparam logic [SET_W-1:0] LAST_SET = SET_W'(SETS - 1);

  state_t           state_q, state_d;
  logic [2:0]       plru_q [SETS];
  logic [SET_W-1:0] set_q;
  logic             hit_q;
  logic [1:0]       way_q;
  logic [1:0]       resp_way_q;
  logic [SET_W-1:0] flush_cnt_q;
  logic [2:0]       cur_state;
  logic [1:0]       miss_way;
  logic             accept;

  // State bits are {b2,b1,b0}: b0 picks the pair, b1/b2 pick within pair {0,1}/{2,3}.
  function automatic logic [1:0] tree_victim(input logic [2:0] s);
    if (s[0]) return s[2] ? 2'd3 : 2'd2;
    else      return s[1] ? 2'd1 : 2'd0;
  endfunction

  // The touched way's path bits are pointed away from it; the other pair's bit is kept.
  function automatic logic [2:0] touch(input logic [2:0] s, input logic [1:0] w);
    logic [2:0] n;
    n = s;
    case (w)
      2'd0: begin n[0] = 1'b1; n[1] = 1'b1; end
      2'd1: begin n[0] = 1'b1; n[1] = 1'b0; end
      2'd2: begin n[0] = 1'b0; n[2] = 1'b1; end
      default: begin n[0] = 1'b0; n[2] = 1'b0; end
    endcase
    return n;
  endfunction

`ifdef PLRU_INVALID_FIRST_EN
  logic [3:0] valid_q;

  function automatic logic [1:0] first_invalid(input logic [3:0] v);
    if (!v[0])      return 2'd0;
    else if (!v[1]) return 2'd1;
    else if (!v[2]) return 2'd2;
    else            return 2'd3;
  endfunction

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0)        valid_q <= 4'b1111;
    else if (accept) valid_q <= way_valid;
  end
`else
  logic unused_way_valid;
  assign unused_way_valid = ^way_valid;
`endif

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; a flush request in IDLE takes priority over a pending request.
  // NOTE: state_d is defaulted first so no path through the case can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (flush_req)      state_d = FLUSH;
        else if (req_valid) state_d = LOOKUP;
      end
      LOOKUP:  state_d = UPDATE;
      UPDATE:  state_d = IDLE;
      FLUSH:   if (flush_cnt_q == LAST_SET) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    req_ready  = (state_q == IDLE) && !flush_req && !rst0;
    resp_valid = (state_q == UPDATE);
    flush_busy = (state_q == FLUSH);
  end

  assign accept   = req_valid && req_ready;
  assign resp_way = resp_way_q;

  assign cur_state = plru_q[set_q];

  always_comb begin
    miss_way = tree_victim(cur_state);
`ifdef PLRU_INVALID_FIRST_EN
    if (valid_q != 4'b1111) miss_way = first_invalid(valid_q);
`endif
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      set_q      <= '0;
      hit_q      <= 1'b0;
      way_q      <= 2'd0;
      resp_way_q <= 2'd0;
    end else begin
      if (accept) begin
        set_q <= req_set;
        hit_q <= req_hit;
        way_q <= req_way;
      end
      if (state_q == LOOKUP) resp_way_q <= hit_q ? way_q : miss_way;
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0)                   flush_cnt_q <= '0;
    else if (state_q == FLUSH)  flush_cnt_q <= flush_cnt_q + 1'b1;
    else                        flush_cnt_q <= '0;
  end

  // NOTE: the PLRU array lives in flops and is reset explicitly, since a reset must leave every
  // set at 3'b000 without waiting for a flush sweep.
  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      for (int i = 0; i < SETS; i++) plru_q[i] <= 3'b000;
    end else if (state_q == UPDATE) begin
      plru_q[set_q] <= touch(cur_state, resp_way_q);
    end else if (state_q == FLUSH) begin
      plru_q[flush_cnt_q] <= 3'b000;
    end
  end

endmodule
